writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Y86-64 SEQ write-back stage and architectural register file.
- Sits at the write end of the register interface that the decode stage reads. Owns the 15 program registers, exported as reg0..reg15.
- Each accepted instruction's valE and valM are committed to their computed destinations on the clock edge.
- Tracks processor status (AOK/HLT/ADR/INS) with a sticky state machine that freezes architectural state on halt or error.

Parameters:
- RSP_INIT, 64'h0000_0000_0000_0000, reset value of reg4 (%rsp).
- OTHER_INIT, 64'h0, reset value of every other register (reg0..reg3, reg5..reg14).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  instruction in write-back this cycle; commit only when high.
- icode  input  4  instruction code.
- ifun  input  4  function code (reserved; no effect on write-back).
- rA  input  4  register specifier A.
- rB  input  4  register specifier B.
- Cnd  input  1  condition result from execute; qualifies cmovXX.
- valE  input  64  ALU result.
- valM  input  64  memory read result.
- imem_error  input  1  fetch address error for this instruction.
- dmem_error  input  1  data memory address error for this instruction.
- reg0..reg15  output  64 each  current register contents; reg15 is the RNONE slot.
- stat  output  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  output  1  high whenever stat != AOK.

Behaviour:
- Reset (synchronous, highest priority):
  - reg4 = RSP_INIT; reg0..3 and reg5..14 = OTHER_INIT; reg15 = 0.
  - stat = AOK; halted = 0.
- Reset mid-operation overrides any commit in the same cycle.
- Destination E (dstE), by icode:
  - 2 (cmovXX): rB if Cnd=1, else none. rrmovq (ifun 0) arrives with Cnd=1.
  - 3 (irmovq), 6 (OPq): rB.
  - 8 (call), 9 (ret), A (pushq), B (popq): 4.
  - All others: none (encoded as 4'hF).
- Destination M (dstM), by icode:
  - 5 (mrmovq), B (popq): rA.
  - All others: none.
- Commit: on rising clk with wb_valid=1 and stat=AOK and the next status is AOK:
  - Write valE to dstE, then valM to dstM.
  - If dstE == dstM, valM wins (popq %rsp yields %rsp = valM).
  - Writes to register 15 are dropped; reg15 reads 0 always.
- Latency: written value is visible on reg outputs the cycle after the commit edge. No internal bypass.
- Next-status priority, evaluated only when wb_valid=1 and stat=AOK:
  - imem_error → ADR.
  - else icode > 4'hB → INS.
  - else dmem_error → ADR.
  - else icode == 0 (halt) → HLT.
  - else AOK.
- Faulting or halting instruction performs no register writes.
- State machine AOK → {HLT, ADR, INS}:
  - Non-AOK states are absorbing until reset.
  - In a non-AOK state all inputs are ignored and the registers are frozen.
- wb_valid=0: no writes, stat unchanged.
- icode 1 (nop), 4 (rmmovq), 7 (jXX): no writes, stat stays AOK.
- All arithmetic is pass-through: 64-bit values stored unmodified, no width conversion.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired, 64 bits.
  - Increments by 1 on each edge where wb_valid=1, stat=AOK and next status is AOK or HLT (halt counts as retired).
  - Cleared by reset; wraps 2^64-1 → 0; frozen once halted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with RSP_INIT=64'h200 → reg4=64'h200, all other regs 0, stat=1, halted=0.
- irmovq (icode 3, rB=2, valE=64'h1234), wb_valid=1 → next cycle reg2=64'h1234. Repeat with rB=F → no register changes.
- cmovle (icode 2, ifun 1, rA=1, rB=3, valE=5):
  - Cnd=0 → reg3 unchanged.
  - Cnd=1 → reg3=5.
- popq %rsp (icode B, rA=4, valE=64'h208, valM=64'hABCD) → reg4=64'hABCD.
- popq %rax (rA=0, valE=64'h210, valM=7) → reg0=7, reg4=64'h210.
- Status transitions:
  - icode 0 → stat=2, halted=1; a following irmovq with wb_valid=1 leaves all regs unchanged.
  - After reset, icode 4'hC → stat=4.
  - After reset, OPq with dmem_error=1 → stat=3 and its dstE is not written.
- Reset asserted in the same cycle as an irmovq to reg1 → reg1=0 and stat=1. With WB_RETIRE_COUNT_EN defined, retired=0 after reset and equals 3 after three nops.

Source files
------------

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage: 15 program registers plus a sticky AOK/HLT/ADR/INS status machine.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_regfile #(
  parameter logic [63:0] RSP_INIT   = 64'h0000_0000_0000_0000,
  parameter logic [63:0] OTHER_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        Cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        imem_error,
  input  logic        dmem_error,
  output logic [63:0] reg0,
  output logic [63:0] reg1,
  output logic [63:0] reg2,
  output logic [63:0] reg3,
  output logic [63:0] reg4,
  output logic [63:0] reg5,
  output logic [63:0] reg6,
  output logic [63:0] reg7,
  output logic [63:0] reg8,
  output logic [63:0] reg9,
  output logic [63:0] reg10,
  output logic [63:0] reg11,
  output logic [63:0] reg12,
  output logic [63:0] reg13,
  output logic [63:0] reg14,
  output logic [63:0] reg15,
  output logic [2:0]  stat,
  output logic        halted
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0] retired
`endif
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RRSP     = 4'h4;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  stat_t       stat_reg;
  stat_t       stat_next;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic        accept;
  logic        commit;
  logic [63:0] regs_reg [0:14];

  // The function code never influences write-back; fold it away explicitly.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    dst_e = RNONE;
    case (icode)
      I_CMOVXX:                         dst_e = Cnd ? rB : RNONE;
      I_IRMOVQ, I_OPQ:                  dst_e = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:   dst_e = RRSP;
      default:                          dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    case (icode)
      I_MRMOVQ, I_POPQ: dst_m = rA;
      default:          dst_m = RNONE;
    endcase
  end

  // Only an instruction seen while AOK can move the status; non-AOK states are absorbing.
  assign accept = wb_valid && (stat_reg == S_AOK);

  always_comb begin
    stat_next = stat_reg;
    if (accept) begin
      if (imem_error) begin
        stat_next = S_ADR;
      end else if (icode > I_POPQ) begin
        stat_next = S_INS;
      end else if (dmem_error) begin
        stat_next = S_ADR;
      end else if (icode == I_HALT) begin
        stat_next = S_HLT;
      end else begin
        stat_next = S_AOK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reg <= S_AOK;
    end else begin
      stat_reg <= stat_next;
    end
  end

  assign commit = accept && (stat_next == S_AOK);

  // valM is checked first so it wins when both destinations name the same register.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_reg
      localparam logic [3:0]  IDX  = 4'(gi);
      localparam logic [63:0] INIT = (gi == 4) ? RSP_INIT : OTHER_INIT;
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_reg[gi] <= INIT;
        end else if (commit && (dst_m == IDX)) begin
          regs_reg[gi] <= valM;
        end else if (commit && (dst_e == IDX)) begin
          regs_reg[gi] <= valE;
        end
      end
    end
  endgenerate

  assign reg0   = regs_reg[0];
  assign reg1   = regs_reg[1];
  assign reg2   = regs_reg[2];
  assign reg3   = regs_reg[3];
  assign reg4   = regs_reg[4];
  assign reg5   = regs_reg[5];
  assign reg6   = regs_reg[6];
  assign reg7   = regs_reg[7];
  assign reg8   = regs_reg[8];
  assign reg9   = regs_reg[9];
  assign reg10  = regs_reg[10];
  assign reg11  = regs_reg[11];
  assign reg12  = regs_reg[12];
  assign reg13  = regs_reg[13];
  assign reg14  = regs_reg[14];
  assign reg15  = 64'h0;
  assign stat   = stat_reg;
  assign halted = (stat_reg != S_AOK);

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retired_reg;

  // A halt retires; faults do not.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_reg <= 64'h0;
    end else if (accept && ((stat_next == S_AOK) || (stat_next == S_HLT))) begin
      retired_reg <= retired_reg + 64'h1;
    end
  end

  assign retired = retired_reg;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an array-based architectural model.
module tb_writeback_regfile;

  localparam logic [63:0] RSP = 64'h200;

  logic        clk = 1'b0;
  logic        reset, wb_valid, Cnd, imem_error, dmem_error;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valE, valM;
  wire  [63:0] dut_regs [16];
  wire  [2:0]  stat;
  wire         halted;
`ifdef WB_RETIRE_COUNT_EN
  wire  [63:0] retired;
`endif

  logic [63:0] model_regs [16];
  int          model_stat;
  logic [63:0] model_retired;
  int          compare_count  = 0;
  int          mismatch_count = 0;
  int          txn_count      = 0;

  always #5 clk = ~clk;

  writeback_regfile #(.RSP_INIT(RSP), .OTHER_INIT(64'h0)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .Cnd(Cnd), .valE(valE), .valM(valM),
    .imem_error(imem_error), .dmem_error(dmem_error),
    .reg0(dut_regs[0]), .reg1(dut_regs[1]), .reg2(dut_regs[2]), .reg3(dut_regs[3]),
    .reg4(dut_regs[4]), .reg5(dut_regs[5]), .reg6(dut_regs[6]), .reg7(dut_regs[7]),
    .reg8(dut_regs[8]), .reg9(dut_regs[9]), .reg10(dut_regs[10]), .reg11(dut_regs[11]),
    .reg12(dut_regs[12]), .reg13(dut_regs[13]), .reg14(dut_regs[14]), .reg15(dut_regs[15]),
    .stat(stat), .halted(halted)
`ifdef WB_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Architectural effect of one clock edge, straight from the ISA rules.
  task automatic model_step(input logic rst, v, input logic [3:0] ic, a, b,
                            input logic c, input logic [63:0] e, m, input logic ie, de);
    int ns, d_e, d_m;
    if (rst) begin
      for (int i = 0; i < 16; i++) model_regs[i] = 64'h0;
      model_regs[4] = RSP;
      model_stat = 1;
      model_retired = 64'h0;
    end else if (v && model_stat == 1) begin
      if (ie)            ns = 3;
      else if (ic > 11)  ns = 4;
      else if (de)       ns = 3;
      else if (ic == 0)  ns = 2;
      else               ns = 1;
      if (ns == 1) begin
        d_e = 15;
        d_m = 15;
        if (ic == 2 && c) d_e = b;
        if (ic == 3 || ic == 6) d_e = b;
        if (ic >= 8 && ic <= 11) d_e = 4;
        if (ic == 5 || ic == 11) d_m = a;
        if (d_e != 15) model_regs[d_e] = e;
        if (d_m != 15) model_regs[d_m] = m;
      end
      if (ns == 1 || ns == 2) model_retired = model_retired + 64'h1;
      model_stat = ns;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) check_value($sformatf("reg%0d", i), dut_regs[i], model_regs[i]);
    check_value("stat", 64'(stat), 64'(model_stat));
    check_value("halted", 64'(halted), 64'(model_stat != 1));
`ifdef WB_RETIRE_COUNT_EN
    check_value("retired", retired, model_retired);
`endif
  endtask

  task automatic run_txn(input logic rst, v, input logic [3:0] ic, fn, a, b,
                         input logic c, input logic [63:0] e, m, input logic ie, de);
    reset = rst; wb_valid = v; icode = ic; ifun = fn; rA = a; rB = b;
    Cnd = c; valE = e; valM = m; imem_error = ie; dmem_error = de;
    @(posedge clk);
    model_step(rst, v, ic, a, b, c, e, m, ie, de);
    #1;
    txn_count++;
    $display("txn %0d rst=%0b v=%0b icode=%h rA=%h rB=%h cnd=%0b ie=%0b de=%0b valE=%h valM=%h -> stat=%0d",
             txn_count, rst, v, ic, a, b, c, ie, de, e, m, stat);
    check_all();
  endtask

  initial begin
    reset = 1'b0; wb_valid = 1'b0; icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    Cnd = 1'b0; valE = 64'h0; valM = 64'h0; imem_error = 1'b0; dmem_error = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 64'h0;
    model_stat = 1;
    model_retired = 64'h0;

    // Directed sequence following the documented scenarios.
    run_txn(1, 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
    check_value("tp_reset_rsp", dut_regs[4], 64'h200);
    check_value("tp_reset_stat", 64'(stat), 64'd1);
    run_txn(0, 1, 4'h3, 4'h0, 4'hF, 4'h2, 0, 64'h1234, 64'h0, 0, 0);
    check_value("tp_irmovq", dut_regs[2], 64'h1234);
    run_txn(0, 1, 4'h3, 4'h0, 4'hF, 4'hF, 0, 64'h9999, 64'h0, 0, 0);
    run_txn(0, 1, 4'h2, 4'h1, 4'h1, 4'h3, 0, 64'h5, 64'h0, 0, 0);
    check_value("tp_cmov_nc", dut_regs[3], 64'h0);
    run_txn(0, 1, 4'h2, 4'h1, 4'h1, 4'h3, 1, 64'h5, 64'h0, 0, 0);
    check_value("tp_cmov_c", dut_regs[3], 64'h5);
    run_txn(0, 1, 4'hB, 4'h0, 4'h4, 4'hF, 0, 64'h208, 64'hABCD, 0, 0);
    check_value("tp_popq_rsp", dut_regs[4], 64'hABCD);
    run_txn(0, 1, 4'hB, 4'h0, 4'h0, 4'hF, 0, 64'h210, 64'h7, 0, 0);
    check_value("tp_popq_rax", dut_regs[0], 64'h7);
    check_value("tp_popq_sp", dut_regs[4], 64'h210);
    run_txn(0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
    check_value("tp_halt", 64'(stat), 64'd2);
    run_txn(0, 1, 4'h3, 4'h0, 4'hF, 4'h5, 0, 64'h55, 64'h0, 0, 0);
    check_value("tp_frozen", dut_regs[5], 64'h0);
    run_txn(1, 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
    run_txn(0, 1, 4'hC, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
    check_value("tp_ins", 64'(stat), 64'd4);
    run_txn(1, 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
    run_txn(0, 1, 4'h6, 4'h0, 4'h1, 4'h6, 0, 64'h66, 64'h0, 0, 1);
    check_value("tp_adr", 64'(stat), 64'd3);
    check_value("tp_adr_nowrite", dut_regs[6], 64'h0);
    run_txn(1, 0, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
    run_txn(0, 1, 4'h3, 4'h0, 4'hF, 4'h1, 0, 64'h11, 64'h0, 0, 0);
    run_txn(1, 1, 4'h3, 4'h0, 4'hF, 4'h1, 0, 64'h77, 64'h0, 0, 0);
    check_value("tp_reset_wins", dut_regs[1], 64'h0);
    for (int i = 0; i < 3; i++) run_txn(0, 1, 4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 0);
`ifdef WB_RETIRE_COUNT_EN
    check_value("tp_retired3", retired, 64'd3);
`endif

    // Randomized traffic, biased toward legal instructions so commits dominate.
    for (int n = 0; n < 400; n++) begin
      logic r, v, c, ie, de;
      logic [3:0] ic;
      r  = (model_stat != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 7) != 0);
      ic = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(1, 11)) : 4'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
      ie = ($urandom_range(0, 39) == 0);
      de = ($urandom_range(0, 39) == 0);
      run_txn(r, v, ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), c, {$urandom, $urandom}, {$urandom, $urandom}, ie, de);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
